// File: rtl/div_clk4_phase_mon.sv
// Phase monitor for a divide-by-4 counter: checks the 0,1,2,3 sequence, declares lock,
// derives a registered div4 clock and phase-0 strobe, and counts sequence errors.
module div_clk4_phase_mon #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_cnt,
  output logic             locked,
  output logic             div4_clk,
  output logic             phase0_stb,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0] LAST = GW'(LOCK_N - 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t          state;
  logic [1:0]      prev_cnt;
  logic [GW-1:0]   good_cnt;
  logic            good;

  // 2-bit compare context makes the 3->0 wrap count as a good step
  assign good = (in_cnt == prev_cnt + 2'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      prev_cnt   <= '0;
      good_cnt   <= '0;
      locked     <= 1'b0;
      div4_clk   <= 1'b0;
      phase0_stb <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      prev_cnt   <= in_cnt;
      div4_clk   <= ~in_cnt[1];
      phase0_stb <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        IDLE: state <= ACQ;
        ACQ: begin
          if (good) begin
            if (good_cnt == LAST) begin
              state      <= LOCK;
              locked     <= 1'b1;
              good_cnt   <= '0;
              phase0_stb <= (in_cnt == 2'd0);
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end else begin
            good_cnt <= '0;
          end
        end
        LOCK: begin
          if (good) begin
            phase0_stb <= (in_cnt == 2'd0);
          end else begin
            state     <= ACQ;
            locked    <= 1'b0;
            good_cnt  <= '0;
            err_pulse <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_clk4_phase_mon.sv
// Bench for div_clk4_phase_mon: two instances (default and LOCK_N=3/ERR_W=2) against a
// run-length reference model: locked whenever the current run of good steps reaches LOCK_N.
module tb_div_clk4_phase_mon;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] in_cnt = 2'd0;

  logic       locked0, div0, stb0, ep0;
  logic [7:0] ec0;
  logic       locked1, div1, stb1, ep1;
  logic [1:0] ec1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  div_clk4_phase_mon #(.LOCK_N(4), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .in_cnt(in_cnt), .locked(locked0), .div4_clk(div0),
    .phase0_stb(stb0), .err_pulse(ep0), .err_cnt(ec0));

  div_clk4_phase_mon #(.LOCK_N(3), .ERR_W(2)) u1 (
    .clk(clk), .rst(rst), .in_cnt(in_cnt), .locked(locked1), .div4_clk(div1),
    .phase0_stb(stb1), .err_pulse(ep1), .err_cnt(ec1));

  always #10 clk = ~clk;

  // reference model state, one slot per instance
  int m_lockn [2] = '{4, 3};
  int m_errmax[2] = '{255, 3};
  bit m_has_prev[2];
  int m_prev[2];
  int m_run[2];
  int m_errs[2];
  bit m_locked[2], m_div[2], m_stb[2], m_ep[2];
  bit period_chk = 0;
  int last_stb = -1;
  int cur = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_has_prev[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_errs[k] = 0;
      m_locked[k] = 0; m_div[k] = 0; m_stb[k] = 0; m_ep[k] = 0;
    end
  endtask

  task automatic model_edge(input int v);
    for (int k = 0; k < 2; k++) begin
      bit g, was;
      m_div[k] = (v < 2);
      if (!m_has_prev[k]) begin
        m_has_prev[k] = 1;
        m_stb[k] = 0; m_ep[k] = 0;
      end else begin
        g = (v == (m_prev[k] + 1) % 4);
        m_run[k] = g ? m_run[k] + 1 : 0;
        was = m_locked[k];
        m_locked[k] = (m_run[k] >= m_lockn[k]);
        m_ep[k] = !g && was;
        if (m_ep[k]) m_errs[k]++;
        m_stb[k] = (v == 0) && g && m_locked[k];
      end
      m_prev[k] = v;
    end
  endtask

  function automatic int sat(input int k);
    return (m_errs[k] > m_errmax[k]) ? m_errmax[k] : m_errs[k];
  endfunction

  task automatic check_all();
    chk("locked0", int'(locked0), int'(m_locked[0]));
    chk("div0",    int'(div0),    int'(m_div[0]));
    chk("stb0",    int'(stb0),    int'(m_stb[0]));
    chk("ep0",     int'(ep0),     int'(m_ep[0]));
    chk("ec0",     int'(ec0),     sat(0));
    chk("locked1", int'(locked1), int'(m_locked[1]));
    chk("div1",    int'(div1),    int'(m_div[1]));
    chk("stb1",    int'(stb1),    int'(m_stb[1]));
    chk("ep1",     int'(ep1),     int'(m_ep[1]));
    chk("ec1",     int'(ec1),     sat(1));
    if (period_chk && stb0) begin
      if (last_stb >= 0) chk("stb_period", cyc - last_stb, 4);
      last_stb = cyc;
    end
  endtask

  // drive a sample, let the edge take it, check 2 ns later
  task automatic step(input int v);
    in_cnt = 2'(v);
    cur = v;
    @(posedge clk);
    cyc++;
    model_edge(v);
    #2;
    check_all();
  endtask

  task automatic good_steps(input int n);
    for (int i = 0; i < n; i++) step((cur + 1) % 4);
  endtask

  task automatic async_reset();
    #5;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_locked", int'(locked0), 0);
    chk("rst_errcnt", int'(ec0), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #5;
    check_all();
    chk("reset_div", int'(div0), 0);
    @(negedge clk);
    rst = 1'b1;

    // clean start: lock after edge 5
    step(0); step(1); step(2); step(3);
    chk("not_locked_e4", int'(locked0), 0);
    step(0);
    chk("locked_e5", int'(locked0), 1);
    chk("stb_e5", int'(stb0), 1);
    good_steps(7);

    // skip 1->3 while locked, then relock on the 4th good step
    step(0); step(1); step(3);
    chk("skip_err", int'(ep0), 1);
    chk("skip_unlock", int'(locked0), 0);
    chk("skip_errcnt", int'(ec0), 1);
    step(0); step(1); step(2);
    chk("relock_wait", int'(locked0), 0);
    step(3); step(0);
    chk("relock", int'(locked0), 1);
    good_steps(3);

    // second error, then async reset while locked with err_cnt=2
    step(3);
    good_steps(6);
    chk("two_errs", int'(ec0), 2);
    async_reset();

    // hold at 2 during acquisition: no error, lock delayed
    step(0); step(1); step(2); step(2); step(2);
    chk("hold_no_err", int'(ec0), 0);
    step(3); step(0); step(1);
    chk("hold_delay", int'(locked0), 0);
    step(2);
    chk("hold_lock", int'(locked0), 1);

    // five lock/error cycles saturate the narrow counter
    for (int i = 0; i < 5; i++) begin
      good_steps(6);
      step(cur);
      chk("sat_pulse", int'(ep1), 1);
    end
    chk("sat_ec1", int'(ec1), 3);

    // randomized: mostly correct steps, occasional hold or skip
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) step(int'($urandom_range(0, 3)));
      else step((cur + 1) % 4);
      if (i == 700) async_reset();
    end

    // long clean run as if from the real counter
    async_reset();
    period_chk = 1;
    step(0);
    good_steps(999);
    chk("clean_errcnt", int'(ec0), 0);
    chk("clean_locked", int'(locked0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
